// File: rtl/video_pkg.sv
// Shared video constants and types for the luma front end of the edge-detection path.
// Sync polarity lives here so every stage agrees on what "asserted" means.
package video_pkg;

  localparam int PIX_W  = 24;
  localparam int LUMA_W = 8;

  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;
  localparam int ROUND  = 128;

  // Product widths sized for 8-bit channels times each coefficient; the
  // rounded sum tops out at 65408, so 16 bits never overflow.
  localparam int PROD_R_W = 15;
  localparam int PROD_G_W = 16;
  localparam int PROD_B_W = 13;
  localparam int SUM_W    = 16;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, blank: 1'b1};

  function automatic logic sync_asserts(input logic prev, input logic cur);
    return (prev != SYNC_ACTIVE) && (cur == SYNC_ACTIVE);
  endfunction

endpackage

// File: rtl/frame_stats.sv
// Per-frame statistics: vsync edge detect, frame-stable threshold, bright-pixel
// count and peak luma, published with a one-cycle valid pulse at each frame start.
module frame_stats
  import video_pkg::*;
#(
  parameter int COUNT_W = 19
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_vsync,
  input  logic               i_blank,
  input  logic               i_above,
  input  logic [LUMA_W-1:0]  i_luma,
  input  logic [LUMA_W-1:0]  i_threshold,
  output logic [LUMA_W-1:0]  o_thr_q,
  output logic [COUNT_W-1:0] o_frame_count,
  output logic [LUMA_W-1:0]  o_frame_max,
  output logic               o_stats_valid
);

  logic               r_vsync_q;
  logic               w_frame_start;
  logic               w_count_hit;
  logic [COUNT_W-1:0] r_acc_cnt;
  logic [COUNT_W-1:0] w_acc_cnt_nxt;
  logic [LUMA_W-1:0]  r_acc_max;
  logic [LUMA_W-1:0]  w_acc_max_nxt;
  logic [LUMA_W-1:0]  r_thr_q;
  logic [COUNT_W-1:0] r_frame_count;
  logic [LUMA_W-1:0]  r_frame_max;
  logic               r_stats_valid;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_acc_cnt_nxt = r_acc_cnt;
    w_acc_max_nxt = r_acc_max;
    w_frame_start = sync_asserts(r_vsync_q, i_vsync);
    w_count_hit   = !i_blank && i_above;
    // A pixel arriving with the frame start belongs to the new frame.
    if (w_frame_start) begin
      w_acc_cnt_nxt = w_count_hit ? COUNT_W'(1) : '0;
      w_acc_max_nxt = i_blank ? '0 : i_luma;
    end else begin
      if (w_count_hit && (r_acc_cnt != '1)) w_acc_cnt_nxt = r_acc_cnt + COUNT_W'(1);
      if (!i_blank && (i_luma > r_acc_max)) w_acc_max_nxt = i_luma;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vsync_q     <= ~SYNC_ACTIVE;
      r_acc_cnt     <= '0;
      r_acc_max     <= '0;
      r_thr_q       <= '0;
      r_frame_count <= '0;
      r_frame_max   <= '0;
      r_stats_valid <= 1'b0;
    end else begin
      r_vsync_q     <= i_vsync;
      r_acc_cnt     <= w_acc_cnt_nxt;
      r_acc_max     <= w_acc_max_nxt;
      r_stats_valid <= w_frame_start;
      if (w_frame_start) begin
        r_frame_count <= r_acc_cnt;
        r_frame_max   <= r_acc_max;
        r_thr_q       <= i_threshold;
      end
    end
  end

  assign o_thr_q       = r_thr_q;
  assign o_frame_count = r_frame_count;
  assign o_frame_max   = r_frame_max;
  assign o_stats_valid = r_stats_valid;

endmodule

// File: rtl/rgb_to_gray.sv
// Three-stage RGB-to-luma pipeline feeding the Sobel stage, with sync/blank
// carried alongside at matching latency and per-frame brightness statistics.
module rgb_to_gray
  import video_pkg::*;
#(
  parameter int COUNT_W = 19
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pixel_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               blank_in,
  input  logic [LUMA_W-1:0]  threshold,
  output logic [LUMA_W-1:0]  gray_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               blank_out,
  output logic               above_out,
  output logic [COUNT_W-1:0] frame_count,
  output logic [LUMA_W-1:0]  frame_max,
  output logic               stats_valid
);

  logic [LUMA_W-1:0]   w_r;
  logic [LUMA_W-1:0]   w_g;
  logic [LUMA_W-1:0]   w_b;
  logic [PROD_R_W-1:0] r_prod_r;
  logic [PROD_G_W-1:0] r_prod_g;
  logic [PROD_B_W-1:0] r_prod_b;
  logic [SUM_W-1:0]    r_sum;
  logic [LUMA_W-1:0]   w_sum_luma;
  logic [LUMA_W-1:0]   r_gray;
  logic                r_above;
  logic [LUMA_W-1:0]   w_thr_q;
  sync_t               w_sync_in;
  sync_t [2:0]         r_sync_d;

  assign w_r        = pixel_in[23:16];
  assign w_g        = pixel_in[15:8];
  assign w_b        = pixel_in[7:0];
  assign w_sync_in  = '{hsync: hsync_in, vsync: vsync_in, blank: blank_in};
  assign w_sum_luma = LUMA_W'(r_sum >> (SUM_W - LUMA_W));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prod_r <= '0;
      r_prod_g <= '0;
      r_prod_b <= '0;
      r_sum    <= '0;
      r_gray   <= '0;
      r_above  <= 1'b0;
      // NOTE: the sync chain resets to idle/blank so stale syncs cannot fake a frame edge.
      r_sync_d <= {3{SYNC_IDLE}};
    end else begin
      // NOTE: non-blocking assignments let every stage read last cycle's value of the previous one.
      r_prod_r <= PROD_R_W'(w_r * COEF_R);
      r_prod_g <= PROD_G_W'(w_g * COEF_G);
      r_prod_b <= PROD_B_W'(w_b * COEF_B);
      r_sum    <= SUM_W'(r_prod_r + r_prod_g + r_prod_b + ROUND);
      r_gray   <= w_sum_luma;
      r_above  <= !r_sync_d[1].blank && (w_sum_luma >= w_thr_q);
      r_sync_d <= {r_sync_d[1:0], w_sync_in};
    end
  end

  frame_stats #(
    .COUNT_W(COUNT_W)
  ) u_frame_stats (
    .clock        (clock),
    .reset        (reset),
    .i_vsync      (r_sync_d[2].vsync),
    .i_blank      (r_sync_d[2].blank),
    .i_above      (r_above),
    .i_luma       (r_gray),
    .i_threshold  (threshold),
    .o_thr_q      (w_thr_q),
    .o_frame_count(frame_count),
    .o_frame_max  (frame_max),
    .o_stats_valid(stats_valid)
  );

  assign gray_out  = r_gray;
  assign above_out = r_above;
  assign hsync_out = r_sync_d[2].hsync;
  assign vsync_out = r_sync_d[2].vsync;
  assign blank_out = r_sync_d[2].blank;

endmodule

// File: tb/tb_rgb_to_gray.sv
// Self-checking bench for rgb_to_gray: every cycle is compared against a
// behavioural luma/frame-statistics model, plus directed frame scenarios.
module tb_rgb_to_gray;

  localparam int CW      = 5;
  localparam int CNT_TOP = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [23:0]   pixel_in = '0;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic          blank_in = 1'b1;
  logic [7:0]    threshold = '0;
  logic [7:0]    gray_out;
  logic          hsync_out;
  logic          vsync_out;
  logic          blank_out;
  logic          above_out;
  logic [CW-1:0] frame_count;
  logic [7:0]    frame_max;
  logic          stats_valid;

  always #5 clock = ~clock;

  rgb_to_gray #(
    .COUNT_W(CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_in   (blank_in),
    .threshold  (threshold),
    .gray_out   (gray_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out),
    .above_out  (above_out),
    .frame_count(frame_count),
    .frame_max  (frame_max),
    .stats_valid(stats_valid)
  );

  typedef struct {
    logic [23:0] pix;
    logic        h;
    logic        v;
    logic        b;
  } rec_t;

  rec_t hist[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: pixels in flight, frame threshold, running and reported stats.
  int m_thr, m_cnt, m_max, m_fc, m_fm, m_pend_cnt, m_pend_max;
  bit m_vprev, m_fell_prev;

  logic [7:0] obs_gray;
  logic       obs_above;
  bit         got_stats;
  int         last_fc, last_fm;

  logic [23:0] prim   [6] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000, 24'h808080};
  int          prim_y [6] = '{77, 149, 29, 255, 0, 128};

  function automatic int luma(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + 128) / 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic reset_model();
    rec_t idle_rec;
    idle_rec = '{pix: 24'h0, h: 1'b1, v: 1'b1, b: 1'b1};
    hist.delete();
    repeat (3) hist.push_back(idle_rec);
    m_thr = 0; m_cnt = 0; m_max = 0; m_fc = 0; m_fm = 0;
    m_pend_cnt = 0; m_pend_max = 0;
    m_vprev = 1'b1; m_fell_prev = 1'b0;
  endtask

  // One clock: drive, advance model, compare every output.
  task automatic step(input logic [23:0] p, input logic h, input logic v, input logic b);
    rec_t r, o;
    int   y;
    bit   ab, fell, exp_valid;
    pixel_in = p; hsync_in = h; vsync_in = v; blank_in = b;
    @(posedge clock);
    #1;
    if (reset) begin
      reset_model();
      o = hist[0];
      exp_valid = 1'b0;
      y = 0;
      ab = 1'b0;
    end else begin
      r = '{pix: p, h: h, v: v, b: b};
      hist.push_back(r);
      void'(hist.pop_front());
      o = hist[0];
      y = luma(o.pix);
      ab = !o.b && (y >= m_thr);
      exp_valid = m_fell_prev;
      if (m_fell_prev) begin
        m_fc  = m_pend_cnt;
        m_fm  = m_pend_max;
        m_thr = int'(threshold);
      end
      fell = m_vprev && !o.v;
      m_vprev = o.v;
      if (fell) begin
        m_pend_cnt = m_cnt; m_pend_max = m_max;
        m_cnt = 0; m_max = 0;
      end
      if (!o.b) begin
        if (ab && m_cnt < CNT_TOP) m_cnt++;
        if (y > m_max) m_max = y;
      end
      m_fell_prev = fell;
    end
    chk("gray", 32'(gray_out), 32'(y));
    chk("hsync", 32'(hsync_out), 32'(o.h));
    chk("vsync", 32'(vsync_out), 32'(o.v));
    chk("blank", 32'(blank_out), 32'(o.b));
    chk("above", 32'(above_out), 32'(ab));
    chk("stats_valid", 32'(stats_valid), 32'(exp_valid));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("frame_max", 32'(frame_max), 32'(m_fm));
    obs_gray  = gray_out;
    obs_above = above_out;
    if (stats_valid) begin
      got_stats = 1'b1;
      last_fc = int'(frame_count);
      last_fm = int'(frame_max);
    end
  endtask

  task automatic act(input logic [23:0] p);
    step(p, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(24'h0, 1'b1, 1'b1, 1'b1);
  endtask

  // Vsync pulse whose first cycle carries pixel p; stats must appear within it.
  task automatic vpulse(input logic [23:0] p, input logic b);
    got_stats = 1'b0;
    step(p, 1'b1, 1'b0, b);
    repeat (3) step(24'h0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(24'h0, 1'b1, 1'b1, 1'b1);
    chk("stats_seen", 32'(got_stats), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    threshold = 8'd100;
    idle(2);
    reset = 1'b0;
    idle(2);
    vpulse(24'h0, 1'b1);
    chk("first_frame_count", 32'(last_fc), 32'd0);

    // Primaries and mid-gray, checked by constant at 3-cycle latency.
    for (int i = 0; i < 8; i++) begin
      act(i < 6 ? prim[i] : 24'h0);
      if (i >= 2) chk("primary_gray", 32'(obs_gray), 32'(prim_y[i-2]));
    end
    idle(1);
    step(24'h0, 1'b0, 1'b1, 1'b1);
    step(24'h0, 1'b0, 1'b1, 1'b1);
    idle(1);
    vpulse(24'h0, 1'b1);
    chk("prim_frame_count", 32'(last_fc), 32'd3);
    chk("prim_frame_max", 32'(last_fm), 32'd255);

    // Threshold 100 frame; threshold moves to 50 mid-frame but must not apply yet.
    act(24'h0A0A0A);
    threshold = 8'd50;
    act(24'hC8C8C8);
    step(24'hFFFFFF, 1'b1, 1'b1, 1'b1);
    act(24'hFFFFFF);
    act(24'h4D4D4D);
    idle(2);
    chk("held_thr_gray", 32'(obs_gray), 32'd77);
    chk("held_thr_above", 32'(obs_above), 32'd0);
    idle(1);
    vpulse(24'h0, 1'b1);
    chk("thr100_count", 32'(last_fc), 32'd2);
    chk("thr100_max", 32'(last_fm), 32'd255);

    // New threshold in force; then a bright pixel coincident with the vsync fall.
    act(24'h4D4D4D);
    act(24'h202020);
    idle(1);
    chk("new_thr_above", 32'(obs_above), 32'd1);
    idle(1);
    vpulse(24'hFFFFFF, 1'b0);
    chk("coincident_close_count", 32'(last_fc), 32'd1);
    chk("coincident_close_max", 32'(last_fm), 32'd77);
    act(24'h3C3C3C);
    idle(3);
    vpulse(24'h0, 1'b1);
    chk("coincident_next_count", 32'(last_fc), 32'd2);
    chk("coincident_next_max", 32'(last_fm), 32'd255);

    // Counter saturation.
    repeat (40) act(24'hFFFFFF);
    idle(3);
    vpulse(24'h0, 1'b1);
    chk("saturated_count", 32'(last_fc), 32'(CNT_TOP));

    // Random frames against the model.
    for (int f = 0; f < 4; f++) begin
      threshold = 8'($urandom_range(0, 255));
      repeat (60) step(24'($urandom), $urandom_range(0, 7) != 0, 1'b1, $urandom_range(0, 3) == 0);
      idle(3);
      vpulse(24'($urandom), 1'($urandom_range(0, 1)));
    end

    // Mid-frame reset discards partial statistics.
    act(24'hFFFFFF);
    act(24'h808080);
    reset = 1'b1;
    act(24'hFFFFFF);
    chk("rst_gray", 32'(obs_gray), 32'd0);
    chk("rst_valid", 32'(stats_valid), 32'd0);
    reset = 1'b0;
    act(24'h0A0A0A);
    act(24'h141414);
    act(24'h1E1E1E);
    idle(3);
    vpulse(24'h0, 1'b1);
    chk("post_reset_count", 32'(last_fc), 32'd3);
    chk("post_reset_max", 32'(last_fm), 32'd30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray.md
# rgb_to_gray

Pipelined colour-to-luma converter on the front of the edge-detection path. It takes the 24-bit RGB video stream and produces the 8-bit grayscale stream the Sobel stage consumes, carrying the sync and blank signals through at matching latency. It also flags each pixel against a programmable threshold and latches per-frame statistics (bright-pixel count, peak luma) at every vertical sync.

## Interface
Parameters:
- `COUNT_W`, default 19: width of the bright-pixel counter; 19 bits covers 640×480.

Ports:
- `clock` in 1: system clock, pixel rate.
- `reset` in 1: synchronous, active-high.
- `pixel_in` in 24: {R[23:16], G[15:8], B[7:0]}.
- `hsync_in`, `vsync_in` in 1 each: active-low syncs.
- `blank_in` in 1: 1 = outside the active region.
- `threshold` in 8: brightness threshold; sampled only at frame boundary.
- `gray_out` out 8: luma.
- `hsync_out`, `vsync_out`, `blank_out` out 1 each: inputs delayed to align with `gray_out`.
- `above_out` out 1: `gray_out >= thr_q` and `blank_out == 0`.
- `frame_count` out COUNT_W: bright-pixel count of the last completed frame.
- `frame_max` out 8: peak active luma of the last completed frame.
- `stats_valid` out 1: one-cycle pulse when `frame_count`/`frame_max` update.

## Operation
- Luma Y = (77·R + 150·G + 29·B + 128) >> 8. The coefficients sum to 256.
- The maximum sum is 65408, which fits in 16 bits, so no saturation logic is needed.
- Pipeline stages:
  - S1 registers three products (15/16/13 bits).
  - S2 registers the 16-bit sum plus 128.
  - S3 registers Y = sum[15:8], together with `above_out`.
- `hsync`, `vsync` and `blank` pass through a 3-deep shift register so they stay aligned with Y.
- `thr_q` is an internal 8-bit register. It loads `threshold` on the cycle a falling edge of `vsync_out` is detected, so the threshold is constant across a frame.
- Accumulators `acc_cnt` and `acc_max` update on each S3 output cycle with `blank_out == 0`:
  - `acc_cnt` increments when `above_out` is set; it saturates at all-ones and never wraps.
  - `acc_max` takes max(`acc_max`, Y).
- Frame close happens on the falling edge of `vsync_out` (previous value 1, current value 0):
  - `frame_count` ← `acc_cnt`, `frame_max` ← `acc_max`, and `stats_valid` pulses for one cycle.
  - Accumulators then restart from this cycle's pixel contribution; if that pixel is blanked they restart from 0.
- Simultaneous event: an active pixel on the same output cycle as the vsync fall counts toward the new frame, not the closing one.
- Reset:
  - Pipeline data, `gray_out`, `above_out`, `thr_q`, accumulators, `frame_count`, `frame_max` and `stats_valid` go to 0.
  - `hsync_out`, `vsync_out`, `blank_out` and the delay chains go to 1 (inactive/blank).
  - On a mid-frame reset, partial statistics are discarded. The first `stats_valid` after reset comes on the first vsync fall seen at the output.

## Timing
- Latency is 3 cycles from `pixel_in` and syncs to `gray_out`, `above_out` and the sync outputs.
- Throughput is one pixel per clock with no stalls.
- `stats_valid` asserts in the cycle after the `vsync_out` fall is registered: 4 cycles after `vsync_in` falls.
- On that same cycle, `frame_count` and `frame_max` update and `thr_q` takes the new threshold. Pixels already in S3 on that cycle use the old threshold.
- Outputs hold their value between updates.

## Structure
- A shared package (`video_pkg`) holds:
  - coefficient constants `COEF_R`=77, `COEF_G`=150, `COEF_B`=29 and `ROUND`=128;
  - `PIX_W`=24 and `LUMA_W`=8;
  - the sync-polarity constant (active-low).
- One sub-module, `frame_stats`, contains the vsync edge detect, threshold latch, accumulators, result registers and `stats_valid`.
- The top level holds the arithmetic pipeline and the delay chains.

## Test plan
- Primaries: 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF and 0x000000 in consecutive cycles → `gray_out` 77, 149, 29, 255, 0, starting 3 cycles later.
- Mid-gray 0x808080 → 128. Random RGB values checked against the formula; syncs and blank match the inputs delayed by 3 cycles.
- Frame with threshold 100 and active lumas 10, 200, 77, 255, plus a blanked pixel at 0xFFFFFF, then vsync falls → `stats_valid` one cycle, `frame_count` 2, `frame_max` 255.
- Threshold changed from 100 to 50 mid-frame → `above_out` still compares against 100 until the vsync fall; from the next frame, luma 77 flags.
- Active pixel with luma 255 coincident at the output with the vsync fall → excluded from the closing frame and counted in the next frame.
- Reset asserted mid-frame → all outputs take their reset values next cycle, with no `stats_valid`. After release, the first vsync fall reports only the pixels seen since reset.
